// File: rtl/scan_decoder_pkg.sv
// Shared types for the scan_decoder block: FSM state encoding and mode values.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

endpackage

// File: rtl/onehot_decoder.sv
// Combinational N-to-2^N one-hot decode with enable; all-zero when disabled.
module onehot_decoder #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [2**SEL_W-1:0]   onehot
);

  // Set exactly the addressed line, or nothing while disabled.
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-select and auto-scan modes.
// Every output is taken straight from a flop; the one-hot pattern is decoded
// from the next-cycle select so out and cur_sel always describe the same line.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_valid,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]    cur_sel,
  output logic                wrap
);

  localparam int OUT_W = 2**SEL_W;

  localparam logic [SEL_W-1:0]   SEL_ONE = SEL_W'(1);
  localparam logic [SEL_W-1:0]   SEL_MAX = '1;
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_t               state;
  state_t               state_nxt;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [DWELL_W-1:0]   cnt_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic                 wrap_nxt;
  logic [OUT_W-1:0]     onehot_nxt;

  // Next-state logic: mode tracking, load priority, dwell counting and advance.
  // The advance decision looks at the registered state, so a mode change only
  // affects advancing from the edge after it is sampled.
  always_comb begin
    state_nxt = state;
    sel_nxt   = cur_sel;
    cnt_nxt   = dwell_cnt;
    wrap_nxt  = 1'b0;
    if (!en) begin
      // Disabled: select and dwell counter hold, outputs blank next cycle.
      state_nxt = IDLE;
    end else begin
      state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
      if (sel_valid) begin
        // A load always wins over a due advance and never flags a wrap.
        sel_nxt = sel;
        cnt_nxt = '0;
      end else if (state == SCAN) begin
        // Compare against the live dwell so a lowered dwell never overruns.
        if (dwell_cnt >= dwell) begin
          sel_nxt  = cur_sel + SEL_ONE;
          cnt_nxt  = '0;
          wrap_nxt = (cur_sel == SEL_MAX);
        end else begin
          cnt_nxt = dwell_cnt + CNT_ONE;
        end
      end
      // Every entry into SCAN starts a fresh dwell on the current line.
      if ((state != SCAN) && (state_nxt == SCAN)) cnt_nxt = '0;
    end
  end

  // One-hot pattern for the line that will be current after this edge,
  // gated by the enable that is being registered alongside it.
  onehot_decoder #(
    .SEL_W (SEL_W)
  ) u_onehot (
    .sel    (sel_nxt),
    .en     (en),
    .onehot (onehot_nxt)
  );

  // State, select, dwell counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_sel   <= '0;
      dwell_cnt <= '0;
      out       <= '0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_sel   <= sel_nxt;
      dwell_cnt <= cnt_nxt;
      out       <= onehot_nxt;
      wrap      <= wrap_nxt;
    end
  end

endmodule
